pipe_ctrl: RTL and testbench

- Central pipeline controller for the 4-stage core (IF, ID, EX, MEM).
- Generates per-stage stall/flush and the redirect PC (new_pc) consumed by the IF pipeline register and downstream stage registers.
- Owns exception/interrupt sequencing: captures EPC and cause, vectors to the handler, and returns on ERET.
- Holds a small control-register file (status, irq mask, EPC, cause) accessed by the EX-stage control-register instructions.

---
 rtl/pipe_ctrl_if.sv | 62 ++++++
 rtl/pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if - bundle of every signal between the pipeline and pipe_ctrl.
//
// Parameters:
//   IRQ_W        number of external interrupt lines (must match pipe_ctrl)
//
// Signals (pipeline -> controller):
//   if_busy, mem_busy        instruction / data bus not ready
//   ld_hazard                load-use dependency seen in ID
//   mem_en, mem_pc           MEM stage valid and its word PC
//   mem_exp_code, mem_eret   MEM exception cause (0 = none), ERET flag
//   irq                      level-sensitive external interrupts
//   creg_wr, creg_addr, creg_wdata   control-register write port
// Signals (controller -> pipeline):
//   creg_rdata               control-register read data
//   *_stall, *_flush         per-stage hold / bubble insert
//   new_pc                   redirect target (valid while if_flush=1)
//   int_en, busy             global interrupt enable, controller not in RUN
//
// Modports: master = pipeline side, slave = pipe_ctrl side.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int IRQ_W = 8
);
    logic             if_busy;
    logic             mem_busy;
    logic             ld_hazard;
    logic             mem_en;
    logic [29:0]      mem_pc;
    logic [2:0]       mem_exp_code;
    logic             mem_eret;
    logic [IRQ_W-1:0] irq;
    logic             creg_wr;
    logic [1:0]       creg_addr;
    logic [31:0]      creg_wdata;
    logic [31:0]      creg_rdata;
    logic             if_stall;
    logic             id_stall;
    logic             ex_stall;
    logic             mem_stall;
    logic             if_flush;
    logic             id_flush;
    logic             ex_flush;
    logic             mem_flush;
    logic [29:0]      new_pc;
    logic             int_en;
    logic             busy;

    modport master (
        output if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_exp_code,
               mem_eret, irq, creg_wr, creg_addr, creg_wdata,
        input  creg_rdata, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc, int_en, busy
    );

    modport slave (
        input  if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_exp_code,
               mem_eret, irq, creg_wr, creg_addr, creg_wdata,
        output creg_rdata, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc, int_en, busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl - central pipeline controller for the IF/ID/EX/MEM core.
//
// Generates per-stage stall/flush, the redirect PC, sequences exceptions,
// interrupts and ERET, and holds the control registers
// (0 status, 1 irq mask, 2 EPC, 3 cause read-only).
//
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset
//   bus     pipe_ctrl_if.slave - all pipeline-facing signals
//
// Configuration macro:
//   PIPE_CTRL_IRQ_EN  when defined, enables the external interrupt path,
//                     the mask register and int_en gating. When undefined,
//                     irq is ignored, mask reads as zero and cause=1 is
//                     never produced.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [29:0] EXCEPT_VECTOR = 30'h0000010,
    parameter int          IRQ_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t       state_r;
    logic         int_en_r;
    logic         pre_int_en_r;
    logic [29:0]  epc_r;
    logic [2:0]   cause_r;
    logic [29:0]  new_pc_r;

    logic         run_s;
    logic         hold_s;
    logic         accept_s;
    logic         irq_hit_s;
    logic         exc_s;
    logic         irq_take_s;
    logic         eret_s;
    logic         redirect_s;
    logic         creg_we_s;
    logic [29:0]  target_s;
    logic [31:0]  mask_rd_s;

`ifdef PIPE_CTRL_IRQ_EN
    logic [IRQ_W-1:0] mask_r;

    // Any unmasked interrupt line raised.
    always_comb begin
        irq_hit_s = |(bus.irq & mask_r);
        mask_rd_s = {{(32-IRQ_W){1'b0}}, mask_r};
    end
`else
    logic unused_irq_s;

    // Interrupt path compiled out: lines are ignored and mask reads zero.
    always_comb begin
        irq_hit_s    = 1'b0;
        mask_rd_s    = 32'h0000_0000;
        unused_irq_s = ^bus.irq;
    end
`endif

    // Event detection and stall/flush/redirect generation.
    always_comb begin
        run_s      = (state_r == ST_RUN);
        hold_s     = bus.if_busy | bus.mem_busy;
        accept_s   = run_s & ~hold_s;
        exc_s      = accept_s & bus.mem_en & (bus.mem_exp_code != 3'd0);
        irq_take_s = accept_s & bus.mem_en & int_en_r & irq_hit_s & ~exc_s;
        eret_s     = accept_s & bus.mem_en & bus.mem_eret & ~exc_s & ~irq_take_s;
        redirect_s = exc_s | irq_take_s | eret_s;
        // Control-register writes lose to any redirect in the same cycle.
        creg_we_s  = accept_s & bus.creg_wr & ~redirect_s;

        bus.if_stall  = 1'b0;
        bus.id_stall  = 1'b0;
        bus.ex_stall  = 1'b0;
        bus.mem_stall = 1'b0;
        bus.if_flush  = 1'b0;
        bus.id_flush  = 1'b0;
        bus.ex_flush  = 1'b0;
        bus.mem_flush = 1'b0;

        if (run_s && hold_s) begin
            // A bus stall freezes the whole pipe and defers every event.
            bus.if_stall  = 1'b1;
            bus.id_stall  = 1'b1;
            bus.ex_stall  = 1'b1;
            bus.mem_stall = 1'b1;
        end else if (redirect_s) begin
            // Redirect overrides any load-use hazard.
            bus.if_flush  = 1'b1;
            bus.id_flush  = 1'b1;
            bus.ex_flush  = 1'b1;
            bus.mem_flush = 1'b1;
        end else if (accept_s && bus.ld_hazard) begin
            // Hold IF/ID, drop a bubble into EX.
            bus.if_stall  = 1'b1;
            bus.id_stall  = 1'b1;
            bus.ex_flush  = 1'b1;
        end else begin
            bus.if_stall  = 1'b0;
        end

        if (eret_s) begin
            target_s = epc_r;
        end else if (exc_s || irq_take_s) begin
            target_s = EXCEPT_VECTOR;
        end else begin
            // Outside a redirect new_pc keeps showing the last target.
            target_s = new_pc_r;
        end
    end

    // Control-register read mux.
    always_comb begin
        case (bus.creg_addr)
            2'd0:    bus.creg_rdata = {30'b0, pre_int_en_r, int_en_r};
            2'd1:    bus.creg_rdata = mask_rd_s;
            2'd2:    bus.creg_rdata = {epc_r, 2'b00};
            2'd3:    bus.creg_rdata = {29'b0, cause_r};
            default: bus.creg_rdata = 32'h0000_0000;
        endcase
    end

    // Drive the remaining outputs from state.
    always_comb begin
        bus.new_pc = target_s;
        bus.int_en = int_en_r;
        bus.busy   = (state_r != ST_RUN);
    end

    // Controller FSM and control-register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_RUN;
            int_en_r     <= 1'b0;
            pre_int_en_r <= 1'b0;
            epc_r        <= 30'h0;
            cause_r      <= 3'd0;
            new_pc_r     <= 30'h0;
`ifdef PIPE_CTRL_IRQ_EN
            mask_r       <= {IRQ_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_s || irq_take_s) begin
                        epc_r        <= bus.mem_pc;
                        cause_r      <= exc_s ? bus.mem_exp_code : 3'd1;
                        pre_int_en_r <= int_en_r;
                        int_en_r     <= 1'b0;
                        new_pc_r     <= EXCEPT_VECTOR;
                        state_r      <= ST_FLUSH;
                    end else if (eret_s) begin
                        int_en_r     <= pre_int_en_r;
                        new_pc_r     <= epc_r;
                        state_r      <= ST_FLUSH;
                    end else if (creg_we_s) begin
                        case (bus.creg_addr)
                            2'd0: begin
                                int_en_r     <= bus.creg_wdata[0];
                                pre_int_en_r <= bus.creg_wdata[1];
                            end
`ifdef PIPE_CTRL_IRQ_EN
                            2'd1:    mask_r <= bus.creg_wdata[IRQ_W-1:0];
`endif
                            2'd2:    epc_r  <= bus.creg_wdata[31:2];
                            default: epc_r  <= epc_r;
                        endcase
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                // One quiet cycle while the bubbles drain; no event accepted.
                ST_FLUSH: state_r <= ST_RUN;
                default:  state_r <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl - self-checking bench for pipe_ctrl.
// Each vector drives inputs, pushes the expected outputs for that cycle onto
// a scoreboard queue, and the entry is popped and compared at the falling
// edge. Expectations that depend on PIPE_CTRL_IRQ_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.IRQ_W(8)) bus ();

    pipe_ctrl #(.EXCEPT_VECTOR(30'h0000010), .IRQ_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  st;   // {if, id, ex, mem} stalls
        logic [3:0]  fl;   // {if, id, ex, mem} flushes
        logic [29:0] np;
        logic        bz;
        logic        ie;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef PIPE_CTRL_IRQ_EN
    localparam bit          IRQ_ON = 1'b1;
    localparam logic [31:0] MASK_E = 32'h4;
    localparam logic [29:0] NP_E   = 30'h300;
`else
    localparam bit          IRQ_ON = 1'b0;
    localparam logic [31:0] MASK_E = 32'h0;
    localparam logic [29:0] NP_E   = 30'h200;
`endif

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic idle();
        bus.if_busy      = 1'b0;
        bus.mem_busy     = 1'b0;
        bus.ld_hazard    = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_pc       = 30'h0;
        bus.mem_exp_code = 3'd0;
        bus.mem_eret     = 1'b0;
        bus.irq          = 8'h00;
        bus.creg_wr      = 1'b0;
        bus.creg_addr    = 2'd0;
        bus.creg_wdata   = 32'h0;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [3:0] fl,
                        input logic [29:0] np, input logic bz, input logic ie,
                        input logic [31:0] rd);
        exp_t e;
        exp_q.push_back('{st: st, fl: fl, np: np, bz: bz, ie: ie, rd: rd});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, ".stall"}, {28'h0, bus.if_stall, bus.id_stall,
                      bus.ex_stall, bus.mem_stall}, {28'h0, e.st});
            check_val({tag, ".flush"}, {28'h0, bus.if_flush, bus.id_flush,
                      bus.ex_flush, bus.mem_flush}, {28'h0, e.fl});
            check_val({tag, ".new_pc"}, {2'b0, bus.new_pc}, {2'b0, e.np});
            check_val({tag, ".busy"}, {31'h0, bus.busy}, {31'h0, e.bz});
            check_val({tag, ".int_en"}, {31'h0, bus.int_en}, {31'h0, e.ie});
            check_val({tag, ".rdata"}, bus.creg_rdata, e.rd);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        bus.creg_addr = 2'd2;
        step("reset", 4'h0, 4'h0, 30'h0, 1'b0, 1'b0, 32'h0);
        bus.ld_hazard = 1'b1;
        step("ldhaz", 4'b1100, 4'b0010, 30'h0, 1'b0, 1'b0, 32'h0);
        step("ldhaz_gone", 4'h0, 4'h0, 30'h0, 1'b0, 1'b0, 32'h0);

        // Software exception, then the same code held during FLUSH.
        bus.mem_en = 1'b1; bus.mem_exp_code = 3'd2; bus.mem_pc = 30'h123;
        bus.creg_addr = 2'd3; bus.ld_hazard = 1'b1;
        step("exc", 4'h0, 4'hF, 30'h10, 1'b0, 1'b0, 32'h0);
        bus.mem_en = 1'b1; bus.mem_exp_code = 3'd2; bus.mem_pc = 30'h456;
        bus.creg_addr = 2'd2;
        step("exc_flush", 4'h0, 4'h0, 30'h10, 1'b1, 1'b0, 32'h48C);
        bus.creg_addr = 2'd3;
        step("exc_cause", 4'h0, 4'h0, 30'h10, 1'b0, 1'b0, 32'h2);

        // Bus stalls defer an exception.
        bus.mem_busy = 1'b1; bus.mem_en = 1'b1; bus.mem_exp_code = 3'd3;
        bus.mem_pc = 30'h200; bus.creg_addr = 2'd2;
        step("membusy", 4'hF, 4'h0, 30'h10, 1'b0, 1'b0, 32'h48C);
        bus.if_busy = 1'b1; bus.mem_en = 1'b1; bus.mem_exp_code = 3'd3;
        bus.mem_pc = 30'h200; bus.creg_addr = 2'd2;
        step("ifbusy", 4'hF, 4'h0, 30'h10, 1'b0, 1'b0, 32'h48C);
        bus.mem_en = 1'b1; bus.mem_exp_code = 3'd3; bus.mem_pc = 30'h200;
        bus.creg_addr = 2'd2;
        step("deferred_exc", 4'h0, 4'hF, 30'h10, 1'b0, 1'b0, 32'h48C);
        bus.creg_addr = 2'd2;
        step("deferred_epc", 4'h0, 4'h0, 30'h10, 1'b1, 1'b0, 32'h800);
        bus.creg_addr = 2'd3;
        step("deferred_cause", 4'h0, 4'h0, 30'h10, 1'b0, 1'b0, 32'h3);

        // Enable interrupts and unmask line 2.
        bus.creg_wr = 1'b1; bus.creg_addr = 2'd0; bus.creg_wdata = 32'h1;
        step("wr_status", 4'h0, 4'h0, 30'h10, 1'b0, 1'b0, 32'h0);
        bus.creg_wr = 1'b1; bus.creg_addr = 2'd1; bus.creg_wdata = 32'h4;
        step("wr_mask", 4'h0, 4'h0, 30'h10, 1'b0, 1'b1, 32'h0);
        bus.creg_addr = 2'd1;
        step("rd_mask", 4'h0, 4'h0, 30'h10, 1'b0, 1'b1, MASK_E);

        bus.irq = 8'h04; bus.mem_en = 1'b1; bus.mem_pc = 30'h300;
        bus.creg_addr = 2'd0;
        step("irq", 4'h0, IRQ_ON ? 4'hF : 4'h0, 30'h10, 1'b0, 1'b1, 32'h1);
        bus.creg_addr = 2'd3;
        step("irq_cause", 4'h0, 4'h0, 30'h10, IRQ_ON, ~IRQ_ON,
             IRQ_ON ? 32'h1 : 32'h3);
        bus.creg_addr = 2'd0;
        step("irq_status", 4'h0, 4'h0, 30'h10, 1'b0, ~IRQ_ON,
             IRQ_ON ? 32'h2 : 32'h1);

        // ERET returns to EPC and restores int_en.
        bus.mem_en = 1'b1; bus.mem_eret = 1'b1; bus.creg_addr = 2'd2;
        step("eret", 4'h0, 4'hF, NP_E, 1'b0, ~IRQ_ON, {NP_E, 2'b00});
        bus.creg_addr = 2'd0;
        step("eret_after", 4'h0, 4'h0, NP_E, 1'b1, IRQ_ON,
             IRQ_ON ? 32'h3 : 32'h0);

        // EPC write, then a write that loses to an exception.
        bus.creg_wr = 1'b1; bus.creg_addr = 2'd2; bus.creg_wdata = 32'h1234;
        step("wr_epc", 4'h0, 4'h0, NP_E, 1'b0, IRQ_ON, {NP_E, 2'b00});
        bus.creg_wr = 1'b1; bus.creg_addr = 2'd2; bus.creg_wdata = 32'hABC;
        bus.mem_en = 1'b1; bus.mem_exp_code = 3'd5; bus.mem_pc = 30'h77;
        step("wr_vs_exc", 4'h0, 4'hF, 30'h10, 1'b0, IRQ_ON, 32'h1234);
        bus.creg_addr = 2'd2;
        step("wr_dropped", 4'h0, 4'h0, 30'h10, 1'b1, 1'b0, 32'h1DC);
        bus.creg_wr = 1'b1; bus.creg_addr = 2'd3; bus.creg_wdata = 32'h7;
        step("wr_cause", 4'h0, 4'h0, 30'h10, 1'b0, 1'b0, 32'h5);
        bus.creg_addr = 2'd3;
        step("cause_ro", 4'h0, 4'h0, 30'h10, 1'b0, 1'b0, 32'h5);
        bus.mem_busy = 1'b1; bus.creg_wr = 1'b1; bus.creg_addr = 2'd2;
        bus.creg_wdata = 32'h0;
        step("wr_busy", 4'hF, 4'h0, 30'h10, 1'b0, 1'b0, 32'h1DC);
        bus.creg_addr = 2'd2;
        step("wr_busy_dropped", 4'h0, 4'h0, 30'h10, 1'b0, 1'b0, 32'h1DC);

        // Reset while in FLUSH.
        bus.mem_en = 1'b1; bus.mem_exp_code = 3'd4; bus.mem_pc = 30'h9;
        bus.creg_addr = 2'd1;
        step("exc_pre_reset", 4'h0, 4'hF, 30'h10, 1'b0, 1'b0, MASK_E);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.creg_addr = 2'd2;
        step("reset_flush", 4'h0, 4'h0, 30'h0, 1'b0, 1'b0, 32'h0);
        bus.creg_addr = 2'd1;
        step("reset_mask", 4'h0, 4'h0, 30'h0, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
